// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The address check is kept here so the responder and anything else agree on what counts as legal.
package dmem_pkg;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int XLEN            = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Misaligned, or any byte-address bit above the word array's span is set.
  function automatic logic addr_err(input logic [XLEN-1:0] addr, input int unsigned addr_w);
    logic [XLEN-1:0] hi_mask;
    hi_mask = ~((XLEN'(1) << (addr_w + 2)) - XLEN'(1));
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || ((addr & hi_mask) != '0);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read, single shared address.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);
  logic [XLEN-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory port: one request at a time, fixed wait states,
// then a held response. Handshake outputs decode straight from the state register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [XLEN-1:0]   mem_rdata;
  logic              err, access, mem_we;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  assign err    = addr_err(addr_q, ADDR_W);
  assign access = (state == WAIT) && (cnt == '0);
  assign mem_we = access && we_q && !err;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid)   state_nx = WAIT;
      WAIT:    if (cnt == '0)   state_nx = RESP;
      RESP:    if (rsp_ready)   state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_W'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Response registers only move at the access edge, so they stay stable through RESP.
      if (access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || we_q) ? '0 : mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven by directed and random traffic
// against a word-array model, plus a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_dmem_responder;
  localparam int WC    = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 0, req_we0 = 0, rsp_ready0 = 0;
  logic [31:0] req_addr0 = 0, req_wdata0 = 0;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [31:0] rsp_rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0));

  int          total = 0, passed = 0, fails = 0;
  int          nresp = 0, nreq = 0;
  logic [31:0] ref_mem [DEPTH];

  int          acc_c[$], rsp_c[$];
  logic [31:0] rsp_d[$];
  logic [31:0] op_addr [4], op_data [4], exp0 [4];
  logic        op_we [4];
  logic        acc;
  int          k, ai;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // One complete transaction on the WAIT_CYCLES=2 instance, with expectations from the word model.
  task automatic do_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    exp_err = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    exp_rd  = (!exp_err && !we) ? ref_mem[addr / 4] : 32'h0;
    nreq++;
    check("idle_ready", req_ready, 1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick();
    // Change the request fields to junk: they must be ignored once accepted.
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    check("busy_after_accept", busy, 1);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check("latency", n, WC + 1);
    check("rdata", rsp_rdata, exp_rd);
    check("err", rsp_err, exp_err);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", rsp_valid, 1);
      check("stall_rdata", rsp_rdata, exp_rd);
      check("stall_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    if (rsp_valid === 1'b0) nresp++;
    check("consumed_valid", rsp_valid, 0);
    check("consumed_ready", req_ready, 1);
    if (!exp_err && we) ref_mem[addr / 4] = wdata;
  endtask

  initial begin
    // Reset state, held while rst_n is low.
    tick();
    check_reset_outputs("por");
    tick();
    check_reset_outputs("por_hold");
    rst_n = 1;
    tick();

    // Fill every word so later loads have a known value.
    for (int i = 0; i < DEPTH; i++) do_xact(1, 32'(i * 4), $urandom, 0);

    do_xact(1, 32'h10, 32'hDEADBEEF, 0);
    do_xact(0, 32'h10, 32'h0, 0);
    do_xact(0, 32'h13, 32'h0, 1);
    do_xact(1, 32'h400, 32'h55AA55AA, 0);
    do_xact(0, 32'h0, 32'h0, 0);
    do_xact(0, 32'h80000000, 32'h0, 0);

    // Load 0x10 stalled 5 cycles while a store to 0x14 is held on the request port.
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    tick();
    req_we = 1; req_addr = 32'h14; req_wdata = 32'hCAFE0014;
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    check("hold_latency", k, WC + 1);
    check("hold_rdata", rsp_rdata, ref_mem[4]);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata_stable", rsp_rdata, ref_mem[4]);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("hold_back_idle", req_ready, 1);
    check("hold_rsp_gone", rsp_valid, 0);
    tick();
    req_valid = 0;
    check("held_req_taken", busy, 1);
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    check("held_latency", k, WC + 1);
    check("held_store_rdata", rsp_rdata, 0);
    check("held_store_err", rsp_err, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    nreq += 2; nresp += 2;
    ref_mem[5] = 32'hCAFE0014;
    do_xact(0, 32'h14, 32'h0, 0);

    // Reset during WAIT of a store: the store must not land.
    do_xact(0, 32'h10, 32'h0, 0);
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h12345678;
    tick();
    req_valid = 0;
    tick();
    check("pre_reset_busy", busy, 1);
    rst_n = 0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    check_reset_outputs("async_rst_hold");
    rst_n = 1;
    tick();
    do_xact(0, 32'h20, 32'h0, 0);

    // Zero-wait instance: request held high, response always taken.
    op_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
    op_addr = '{32'h8, 32'h8, 32'hC, 32'hC};
    op_data = '{32'hA5A50001, 32'h0, 32'h0BADF00D, 32'h0};
    exp0    = '{32'h0, 32'hA5A50001, 32'h0, 32'h0BADF00D};
    ai = 0;
    req_valid0 = 1; req_we0 = op_we[0]; req_addr0 = op_addr[0]; req_wdata0 = op_data[0];
    rsp_ready0 = 1;
    for (int c = 1; c <= 14; c++) begin
      acc = req_ready0 && req_valid0;
      tick();
      if (acc) begin
        acc_c.push_back(c);
        ai++;
        if (ai < 4) begin
          req_we0 = op_we[ai]; req_addr0 = op_addr[ai]; req_wdata0 = op_data[ai];
        end else req_valid0 = 0;
      end
      if (rsp_valid0) begin
        rsp_c.push_back(c);
        rsp_d.push_back(rsp_rdata0);
      end
    end
    rsp_ready0 = 0;
    check("wc0_accepts", acc_c.size(), 4);
    check("wc0_responses", rsp_c.size(), 4);
    for (int i = 0; i < 4 && i < acc_c.size() && i < rsp_c.size(); i++) begin
      check("wc0_latency", rsp_c[i] - acc_c[i], 1);
      check("wc0_rdata", rsp_d[i], exp0[i]);
      if (i > 0) check("wc0_spacing", acc_c[i] - acc_c[i-1], 3);
    end

    // Random mix of loads/stores, some illegal, with random response stalls.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 9);
      a = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = a | (32'h1 << $urandom_range(10, 31));
      do_xact(1'($urandom_range(0, 1)), a, $urandom,
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
    end
    check("response_count", nresp, nreq);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
